// File: rtl/rr_mux8.sv
// 8-to-1 round-robin packet multiplexer with a single output register.
// Each beat is tagged with its source channel so a downstream demux can split the stream again.
module rr_mux8 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          in_valid,
    input  logic [7:0]          in_last,
    input  logic [8*DATA_W-1:0] in_data,
    output logic [7:0]          in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [2:0]          out_sel,
    output logic                out_last,
    input  logic                out_ready
);

    typedef enum logic [0:0] {StArb, StPkt} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [2:0]        r_ptr;
    logic [2:0]        r_lock;
    logic [2:0]        w_grant;
    logic [2:0]        w_ch;
    logic              w_found;
    logic              w_space;
    logic              w_accept;
    logic              w_beat_last;
    logic [DATA_W-1:0] w_beat_data;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [2:0]        r_out_sel;
    logic              r_out_last;

    assign w_space = !r_out_valid || out_ready;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_ptr;
        for (int k = 7; k >= 0; k--) begin
            if (in_valid[r_ptr + 3'(k)]) begin
                w_found = 1'b1;
                w_grant = r_ptr + 3'(k);
            end
        end
    end

    // rst_n gates in_ready so it drops immediately, without waiting for a clock edge.
    always_comb begin
        in_ready = 8'h00;
        w_ch     = (r_state == StPkt) ? r_lock : w_grant;
        if (rst_n && w_space && ((r_state == StPkt) || w_found)) begin
            in_ready[w_ch] = 1'b1;
        end
    end

    assign w_accept    = |(in_valid & in_ready);
    assign w_beat_last = in_last[w_ch];

    always_comb begin
        w_beat_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (w_ch == 3'(i)) begin
                w_beat_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = w_beat_last ? StArb : StPkt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StArb;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= 3'd0;
            r_lock <= 3'd0;
        end else if (w_accept) begin
            r_lock <= w_ch;
            if (w_beat_last) begin
                r_ptr <= w_ch + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 3'd0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_beat_data;
            r_out_sel   <= w_ch;
            r_out_last  <= w_beat_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_last  = r_out_last;

endmodule
